weighted_grant_sequencer: RTL and testbench

- Sequences access from four bus clients to one shared server using a request/grant/acknowledge handshake.
- Arbitration is weighted round-robin: each client may hold the server for up to N acknowledged transfers before the pointer moves on.
- A watchdog releases a grant if the server never acknowledges.
- Sits between the client request lines and the server port in the bus arbiter top level.

---
 rtl/arbiter_pkg.sv | 32 +++
 rtl/rr_next_client.sv | 41 ++++
 rtl/weighted_grant_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_weighted_grant_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared types, sizes and helpers for the weighted grant
//               sequencer and its round-robin search sub-block.
// Revision    : 1.0  initial release
// ============================================================================
package arbiter_pkg;

  // Client count and address width are fixed for this arbiter family.
  localparam int NUMBER_OF_CLIENTS = 4;
  localparam int CLIENT_ADDR_WIDTH = 2;

  // Sequencer states. ARB always lasts exactly one cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  // One-hot grant vector for a client index.
  function automatic logic [NUMBER_OF_CLIENTS-1:0] onehot_from_addr(
    input logic [CLIENT_ADDR_WIDTH-1:0] addr
  );
    logic [NUMBER_OF_CLIENTS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next_client.sv
`default_nettype none
// ============================================================================
// Module      : rr_next_client
// Description : Combinational round-robin search. Scans the request vector
//               starting at the pointer and wrapping, and returns the first
//               requesting client together with a found flag.
// Revision    : 1.0  initial release
// ============================================================================
module rr_next_client
  import arbiter_pkg::*;
(
  input  logic [CLIENT_ADDR_WIDTH-1:0] ptr_i,
  input  logic [NUMBER_OF_CLIENTS-1:0] req_i,
  output logic                         found_o,
  output logic [CLIENT_ADDR_WIDTH-1:0] idx_o
);

  logic                         hit;
  logic [CLIENT_ADDR_WIDTH-1:0] cand;
  logic [CLIENT_ADDR_WIDTH-1:0] pick;

  // Walk pointer, pointer+1, ... (modulo client count); first set bit wins.
  always_comb begin
    hit  = 1'b0;
    cand = ptr_i;
    pick = ptr_i;
    for (int k = 0; k < NUMBER_OF_CLIENTS; k++) begin
      // Address arithmetic wraps naturally because the count is 2**width.
      cand = ptr_i + CLIENT_ADDR_WIDTH'(k);
      if (!hit && req_i[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  assign found_o = hit;
  assign idx_o   = pick;

endmodule
`default_nettype wire

// File: rtl/weighted_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : weighted_grant_sequencer
// Description : Weighted round-robin sequencer between four bus clients and
//               one shared server. A granted client may keep the server for
//               up to its weight in acknowledged transfers; a watchdog
//               releases a grant the server never acknowledges.
// Revision    : 1.0  initial release
// ============================================================================
module weighted_grant_sequencer
  import arbiter_pkg::*;
#(
  parameter int CREDIT_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [NUMBER_OF_CLIENTS-1:0]              client_rq,
  input  logic [NUMBER_OF_CLIENTS*CREDIT_WIDTH-1:0] weight_cfg,
  input  logic                                      server_ack,
  output logic                                      server_req,
  output logic [CLIENT_ADDR_WIDTH-1:0]              address_to_be_served,
  output logic [NUMBER_OF_CLIENTS-1:0]              client_gnt,
  output logic                                      timeout_err,
  output logic                                      busy
);

  localparam int TCNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_WIDTH-1:0]        TCNT_LAST  = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CREDIT_WIDTH-1:0]      CREDIT_ONE = CREDIT_WIDTH'(1);
  localparam logic [CLIENT_ADDR_WIDTH-1:0] ADDR_ONE   = CLIENT_ADDR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e                                        state_q, state_d;
  logic [CLIENT_ADDR_WIDTH-1:0]                  ptr_q, ptr_d;
  logic [CLIENT_ADDR_WIDTH-1:0]                  addr_q, addr_d;
  logic [NUMBER_OF_CLIENTS-1:0][CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic [TCNT_WIDTH-1:0]                         tcnt_q, tcnt_d;

  // Registered outputs
  logic                         req_q, req_d;
  logic [NUMBER_OF_CLIENTS-1:0] gnt_q, gnt_d;
  logic                         terr_q, terr_d;
  logic                         busy_q, busy_d;

  // --------------------------------------------------------------------------
  // Reload values: a configured weight of 0 still allows one transfer.
  // --------------------------------------------------------------------------
  logic [NUMBER_OF_CLIENTS-1:0][CREDIT_WIDTH-1:0] reload_w;

  for (genvar i = 0; i < NUMBER_OF_CLIENTS; i++) begin : g_reload
    logic [CREDIT_WIDTH-1:0] raw;
    assign raw         = weight_cfg[i*CREDIT_WIDTH +: CREDIT_WIDTH];
    assign reload_w[i] = (raw == '0) ? CREDIT_ONE : raw;
  end

  // --------------------------------------------------------------------------
  // Round-robin search from the current pointer
  // --------------------------------------------------------------------------
  logic                         rr_found;
  logic [CLIENT_ADDR_WIDTH-1:0] rr_idx;

  rr_next_client u_rr_next_client (
    .ptr_i   (ptr_q),
    .req_i   (client_rq),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  // --------------------------------------------------------------------------
  // Next-state, credit, pointer and watchdog decisions
  // --------------------------------------------------------------------------
  // Next-state logic: ack beats withdrawal, which beats the watchdog.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    credit_d = credit_q;
    tcnt_d   = '0;
    terr_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && (|client_rq)) begin
          state_d = ST_ARB;
        end
      end

      ST_ARB: begin
        // Requests may vanish during ARB; fall back to IDLE with no grant.
        if (rr_found) begin
          addr_d  = rr_idx;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (server_ack) begin
          if (credit_q[addr_q] == CREDIT_ONE) begin
            // Burst budget used up: reload and hand the pointer onward.
            credit_d[addr_q] = reload_w[addr_q];
            ptr_d            = addr_q + ADDR_ONE;
            state_d          = ST_IDLE;
          end else begin
            credit_d[addr_q] = credit_q[addr_q] - CREDIT_ONE;
            if (client_rq[addr_q]) begin
              // Back-to-back transfer for the same client, no re-arbitration.
              state_d = ST_GRANT;
            end else begin
              // Client finished early; it keeps the remaining credit.
              ptr_d   = addr_q + ADDR_ONE;
              state_d = ST_IDLE;
            end
          end
        end else if (!client_rq[addr_q]) begin
          // Withdrawn without a transfer: nothing was consumed.
          state_d = ST_IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          // Server is unresponsive: release the grant and move on.
          terr_d           = 1'b1;
          credit_d[addr_q] = reload_w[addr_q];
          ptr_d            = addr_q + ADDR_ONE;
          state_d          = ST_IDLE;
        end else begin
          tcnt_d  = tcnt_q + TCNT_WIDTH'(1);
          state_d = ST_GRANT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    req_d  = (state_d == ST_GRANT);
    gnt_d  = req_d ? onehot_from_addr(addr_d) : '0;
    busy_d = (state_d != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // State register with synchronous reset; reset also reloads every credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      addr_q   <= '0;
      credit_q <= reload_w;
      tcnt_q   <= '0;
      req_q    <= 1'b0;
      gnt_q    <= '0;
      terr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      tcnt_q   <= tcnt_d;
      req_q    <= req_d;
      gnt_q    <= gnt_d;
      terr_q   <= terr_d;
      busy_q   <= busy_d;
    end
  end

  assign server_req           = req_q;
  assign address_to_be_served = addr_q;
  assign client_gnt           = gnt_q;
  assign timeout_err          = terr_q;
  assign busy                 = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_weighted_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weighted_grant_sequencer
// Description : Directed self-checking bench for weighted_grant_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_weighted_grant_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  client_rq;
  logic [11:0] weight_cfg;
  logic        server_ack;
  logic        server_req;
  logic [1:0]  address_to_be_served;
  logic [3:0]  client_gnt;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  weighted_grant_sequencer #(
    .CREDIT_WIDTH   (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .client_rq            (client_rq),
    .weight_cfg           (weight_cfg),
    .server_ack           (server_ack),
    .server_req           (server_req),
    .address_to_be_served (address_to_be_served),
    .client_gnt           (client_gnt),
    .timeout_err          (timeout_err),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // idx < 0 means no grant expected.
  task automatic chk_grant(input string tag, input int idx);
    logic [3:0] exp_gnt;
    exp_gnt = (idx < 0) ? 4'b0000 : 4'(1 << idx);
    chk({tag, ".gnt"}, 32'(client_gnt), 32'(exp_gnt));
    chk({tag, ".req"}, 32'(server_req), 32'(idx >= 0));
    if (idx >= 0) chk({tag, ".addr"}, 32'(address_to_be_served), 32'(idx));
  endtask

  // Client 4 weight in the MSBs, client 1 in the LSBs.
  function automatic logic [11:0] wcfg(input int w3, input int w2, input int w1, input int w0);
    return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    client_rq  = 4'b0000;
    server_ack = 1'b0;
    weight_cfg = wcfg(1, 1, 1, 1);
    do_reset();

    // Reset state
    chk("rst.req",  32'(server_req), 0);
    chk("rst.gnt",  32'(client_gnt), 0);
    chk("rst.addr", 32'(address_to_be_served), 0);
    chk("rst.terr", 32'(timeout_err), 0);
    chk("rst.busy", 32'(busy), 0);

    // Equal weights, everyone requests, ack always high: 0,1,2,3,0
    enable = 1'b1; client_rq = 4'b1111; server_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr.arb_busy", 32'(busy), 1);
      chk_grant("rr.arb", -1);
      tick();
      chk_grant("rr.grant", order[k]);
      tick();
      chk_grant("rr.idle", -1);
      chk("rr.terr", 32'(timeout_err), 0);
    end
    enable = 1'b0; client_rq = 4'b0000; server_ack = 1'b0;

    // Client 1 weight 3, clients 1 and 2 request, ack every cycle
    weight_cfg = wcfg(1, 1, 1, 3);
    do_reset();
    enable = 1'b1; client_rq = 4'b0011; server_ack = 1'b1;
    tick();
    tick(); chk_grant("w3.burst0", 0);
    tick(); chk_grant("w3.burst1", 0);
    tick(); chk_grant("w3.burst2", 0);
    tick(); chk_grant("w3.exhaust", -1);
    tick();
    tick(); chk_grant("w3.next", 1);
    tick(); chk_grant("w3.next_done", -1);
    tick();
    tick(); chk_grant("w3.wrap", 0);
    // Withdrawal without ack aborts to IDLE
    enable = 1'b0; client_rq = 4'b0000; server_ack = 1'b0;
    tick(); chk_grant("abort", -1);
    tick(); chk("abort.busy", 32'(busy), 0);

    // Watchdog on client 3 (index 2)
    enable = 1'b1; client_rq = 4'b0100;
    tick();
    tick(); chk_grant("wd.first", 2);
    repeat (15) tick();
    chk_grant("wd.last", 2);
    chk("wd.noerr", 32'(timeout_err), 0);
    tick();
    chk("wd.fire", 32'(timeout_err), 1);
    chk_grant("wd.release", -1);
    client_rq = 4'b1111;
    tick();
    chk("wd.pulse_end", 32'(timeout_err), 0);
    tick(); chk_grant("wd.ptr3", 3);
    enable = 1'b0; client_rq = 4'b0000; server_ack = 1'b1;
    tick(); chk_grant("wd.after", -1);
    server_ack = 1'b0;

    // Early withdrawal on ack keeps remaining credit, pointer moves on
    weight_cfg = wcfg(1, 1, 4, 1);
    do_reset();
    enable = 1'b1; client_rq = 4'b0010;
    tick();
    tick(); chk_grant("keep.grant", 1);
    client_rq = 4'b0000; server_ack = 1'b1;
    tick(); chk_grant("keep.leave", -1);
    server_ack = 1'b0; client_rq = 4'b0110;
    tick();
    tick(); chk_grant("keep.ptr2", 2);
    client_rq = 4'b0010; server_ack = 1'b1;
    tick(); chk_grant("keep.c2done", -1);
    tick();
    tick(); chk_grant("keep.res0", 1);
    tick(); chk_grant("keep.res1", 1);
    tick(); chk_grant("keep.res2", 1);
    tick(); chk_grant("keep.res_out", -1);
    enable = 1'b0; client_rq = 4'b0000; server_ack = 1'b0;

    // Ack in the same cycle the watchdog would expire
    enable = 1'b1; client_rq = 4'b0010;
    tick();
    tick(); chk_grant("ackwd.first", 1);
    repeat (15) tick();
    chk_grant("ackwd.pre", 1);
    server_ack = 1'b1;
    tick();
    chk("ackwd.noerr", 32'(timeout_err), 0);
    chk_grant("ackwd.stay", 1);
    server_ack = 1'b0;
    tick();
    chk("ackwd.noerr2", 32'(timeout_err), 0);
    chk_grant("ackwd.stay2", 1);

    // Reset in GRANT with an ack pending
    server_ack = 1'b1; reset = 1'b1;
    tick();
    chk_grant("rstg", -1);
    chk("rstg.addr", 32'(address_to_be_served), 0);
    chk("rstg.busy", 32'(busy), 0);
    chk("rstg.terr", 32'(timeout_err), 0);
    reset = 1'b0; enable = 1'b0; client_rq = 4'b1111; server_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dis.busy", 32'(busy), 0);
      chk("dis.gnt", 32'(client_gnt), 0);
    end
    enable = 1'b1;
    tick(); chk("dis.arb", 32'(busy), 1);
    tick(); chk_grant("dis.ptr0", 0);

    // Weight 0 behaves as weight 1
    weight_cfg = wcfg(0, 1, 1, 1);
    do_reset();
    enable = 1'b1; client_rq = 4'b1000; server_ack = 1'b1;
    tick();
    tick(); chk_grant("w0.grant", 3);
    tick(); chk_grant("w0.once", -1);
    enable = 1'b0; client_rq = 4'b0000; server_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
